// File: rtl/synch_memory.sv
// Single-port synchronous RAM on a shared bidirectional data bus, one-cycle read latency.
// Optional per-word even parity with a parity_err output when SYNCH_MEMORY_PARITY_EN is defined.
module synch_memory #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data
`ifdef SYNCH_MEMORY_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_d;
  logic              wr_c;
  logic              rd_c;
  logic              drive_c;

  // Edge actions and the bus drive window; the drive window tracks enable/we
  // combinationally so the bus is released in the same cycle we rises.
  assign wr_c    = enable & we;
  assign rd_c    = enable & ~we;
  assign drive_c = rst_n & enable & ~we;

  always_comb begin
    rd_d = rd_q;
    if (rd_c) begin
      rd_d = mem_q[address];
    end
  end

  // Storage array; an asserted reset discards any in-flight write and clears every word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_W'(i)] <= '0;
      end
    end else if (wr_c) begin
      mem_q[address] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign data = drive_c ? rd_q : {DATA_W{1'bz}};

`ifdef SYNCH_MEMORY_PARITY_EN
  logic par_q [DEPTH];
  logic rd_par_q;
  logic rd_par_d;

  always_comb begin
    rd_par_d = rd_par_q;
    if (rd_c) begin
      rd_par_d = par_q[address];
    end
  end

  // Even parity: the stored bit makes the XOR over data plus parity zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        par_q[ADDR_W'(i)] <= 1'b0;
      end
      rd_par_q <= 1'b0;
    end else begin
      if (wr_c) begin
        par_q[address] <= ^data;
      end
      rd_par_q <= rd_par_d;
    end
  end

  assign parity_err = drive_c & ((^rd_q) ^ rd_par_q);
`endif

endmodule

// File: tb/tb_synch_memory.sv
// Self-checking bench for synch_memory: directed phases plus random traffic against a behavioural model.
// Parity checks are compiled in when SYNCH_MEMORY_PARITY_EN is defined.
module tb_synch_memory;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] address = '0;
  wire  [DW-1:0] data;
  logic          mdrv = 1'b0;
  logic [DW-1:0] mdata = '0;
`ifdef SYNCH_MEMORY_PARITY_EN
  logic          parity_err;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model: word array, read register, stored parity.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_par [DEPTH];
  logic [DW-1:0] m_rd;
  logic          m_rdpar;

  assign data = mdrv ? mdata : {DW{1'bz}};

  synch_memory #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .we      (we),
    .address (address),
    .data    (data)
`ifdef SYNCH_MEMORY_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic dut_drives();
    return rst_n && enable && !we;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_mem[i] = '0;
      m_par[i] = 1'b0;
    end
    m_rd = '0;
    m_rdpar = 1'b0;
  endtask

  task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: data got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle check: bus shows the read register when the DUT owns it, otherwise the master value.
  task automatic check_bus(input string name);
    cmp(name, data, dut_drives() ? m_rd : mdata);
`ifdef SYNCH_MEMORY_PARITY_EN
    n_chk++;
    if (parity_err !== (dut_drives() ? ((^m_rd) ^ m_rdpar) : 1'b0)) begin
      n_fail++;
      $display("FAIL %s_parity: parity_err got %b expected %b", name, parity_err,
               dut_drives() ? ((^m_rd) ^ m_rdpar) : 1'b0);
    end
`endif
  endtask

  // Apply inputs, clock one edge, update the model, sample 1ns after the edge.
  task automatic cyc(input logic en, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] v, input string name);
    enable  = en;
    we      = w;
    address = a;
    mdata   = v;
    mdrv    = !(rst_n && en && !w);
    @(posedge clk);
    if (rst_n && en) begin
      if (w) begin
        m_mem[a] = v;
        m_par[a] = ^v;
      end else begin
        m_rd    = m_mem[a];
        m_rdpar = m_par[a];
      end
    end
    #1;
    check_bus(name);
  endtask

  logic [DW-1:0] fib [6];

  initial begin
    fib[0] = 8'h01; fib[1] = 8'h02; fib[2] = 8'h03;
    fib[3] = 8'h05; fib[4] = 8'h08; fib[5] = 8'h0D;
    model_reset();

    // Reset held from t=0 with enable low; master parks a value on the bus.
    mdrv = 1'b1;
    mdata = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check_bus("reset_bus");
    @(negedge clk);
    rst_n = 1'b1;

    // Post-reset reads of every word return zero.
    for (int i = 0; i < int'(DEPTH); i++) begin
      cyc(1'b1, 1'b0, AW'(i), 8'h00, "reset_read");
      cmp("reset_read_lit", data, 8'h00);
    end

    // Fibonacci writes, each held for several edges; bus must show master data.
    for (int i = 0; i < 6; i++) begin
      repeat (3) cyc(1'b1, 1'b1, AW'(i), fib[i], "fib_write");
    end

    // we falls mid-cycle: DUT takes the bus before the next edge.
    enable = 1'b1; we = 1'b0; address = '0; mdrv = 1'b0;
    #1;
    check_bus("bus_takeover");

    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, AW'(i), 8'h00, "fib_read");
      cmp("fib_read_lit", data, fib[i]);
      cyc(1'b1, 1'b0, AW'(i), 8'h00, "fib_hold");
    end

    // Disabled write attempts are ignored.
    repeat (4) cyc(1'b0, 1'b1, AW'(3), 8'hFF, "disable_bus");
    cyc(1'b1, 1'b0, AW'(3), 8'h00, "disable_read");
    cmp("disable_read_lit", data, 8'h05);

    // Async reset between edges with a read in progress and master parked.
    cyc(1'b1, 1'b0, AW'(4), 8'h00, "pre_reset_read");
    #2;
    mdrv = 1'b1;
    mdata = 8'h3C;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_bus("async_reset_bus");
    mdrv = 1'b0;
    rst_n = 1'b1;
    #1;
    cmp("async_reset_rdq", data, 8'h00);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, AW'(i), 8'h00, "after_reset_read");
      cmp("after_reset_lit", data, 8'h00);
    end

`ifdef SYNCH_MEMORY_PARITY_EN
    // Corrupt the stored parity of word 9 and expect the error on its read.
    cyc(1'b1, 1'b1, AW'(9), 8'h07, "par_write");
    @(negedge clk);
    dut.par_q[9] = ~dut.par_q[9];
    m_par[9] = ~m_par[9];
    cyc(1'b1, 1'b0, AW'(9), 8'h00, "par_read_bad");
    n_chk++;
    if (parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL par_err_lit: parity_err got %b expected 1", parity_err);
    end
    cyc(1'b1, 1'b0, AW'(0), 8'h00, "par_read_clean");
    n_chk++;
    if (parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL par_clean_lit: parity_err got %b expected 0", parity_err);
    end
    cyc(1'b1, 1'b1, AW'(9), 8'h07, "par_rewrite");
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
          AW'($urandom_range(0, DEPTH - 1)), DW'($urandom), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
